// File: rtl/s_p_deserializer.sv
// Framed serial-to-parallel deserializer with a valid/ready word output.
// Define S_P_DESER_PARITY_EN to require a trailing even-parity beat after each word.
module s_p_deserializer #(
    parameter int unsigned WIDTH     = 256,
    parameter int unsigned LANES     = 1,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             SIN_VALID,
    input  logic             SIN_SYNC,
    input  logic [LANES-1:0] SIN_DATA,
    output logic [WIDTH-1:0] POUT_DATA,
    output logic             POUT_VALID,
    input  logic             POUT_READY,
    output logic             OVERRUN,
    output logic             FRAME_ERR
);
    localparam int unsigned BEATS = WIDTH / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

`ifdef S_P_DESER_PARITY_EN
    typedef enum logic [1:0] {StHunt, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StHunt, StShift} state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sr_shift, sr_first;
    logic [WIDTH-1:0] pout_data_q, pout_data_d;
    logic             pout_valid_q, pout_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic             word_done;

    // sr_first restarts the word from a sync beat so no stale partial bits survive.
    if (MSB_FIRST) begin : g_msb_first
        assign sr_shift = {sr_q[WIDTH-LANES-1:0], SIN_DATA};
        assign sr_first = {{(WIDTH-LANES){1'b0}}, SIN_DATA};
    end else begin : g_lsb_first
        assign sr_shift = {SIN_DATA, sr_q[WIDTH-1:LANES]};
        assign sr_first = {SIN_DATA, {(WIDTH-LANES){1'b0}}};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        word_done   = 1'b0;
        frame_err_d = 1'b0;
        if (SIN_VALID) begin
            unique case (state_q)
                StHunt: begin
                    if (SIN_SYNC) begin
                        sr_d    = sr_first;
                        cnt_d   = ONE;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (SIN_SYNC && (cnt_q != '0)) begin
                        sr_d        = sr_first;
                        cnt_d       = ONE;
                        frame_err_d = 1'b1;
                    end else if (cnt_q == LAST_BEAT) begin
                        sr_d  = sr_shift;
                        cnt_d = '0;
`ifdef S_P_DESER_PARITY_EN
                        state_d = StParity;
`else
                        word_done = 1'b1;
`endif
                    end else begin
                        sr_d  = sr_shift;
                        cnt_d = cnt_q + ONE;
                    end
                end
`ifdef S_P_DESER_PARITY_EN
                StParity: begin
                    state_d = StShift;
                    if (SIN_SYNC) begin
                        sr_d        = sr_first;
                        cnt_d       = ONE;
                        frame_err_d = 1'b1;
                    end else if ((^sr_q) ^ SIN_DATA[0]) begin
                        frame_err_d = 1'b1;
                    end else begin
                        word_done = 1'b1;
                    end
                end
`endif
                default: state_d = StHunt;
            endcase
        end
    end

    // A completed word is sr_d in both modes: the parity branch leaves sr untouched.
    always_comb begin
        pout_data_d  = pout_data_q;
        pout_valid_d = pout_valid_q;
        overrun_d    = 1'b0;
        if (word_done) begin
            if (!pout_valid_q || POUT_READY) begin
                pout_data_d  = sr_d;
                pout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (pout_valid_q && POUT_READY) begin
            pout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q      <= StHunt;
            cnt_q        <= '0;
            sr_q         <= '0;
            pout_data_q  <= '0;
            pout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            pout_data_q  <= pout_data_d;
            pout_valid_q <= pout_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign POUT_DATA  = pout_data_q;
    assign POUT_VALID = pout_valid_q;
    assign OVERRUN    = overrun_q;
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_s_p_deserializer.sv
// Directed bench for s_p_deserializer: three 8-bit instances (MSB-first, LSB-first, 2-lane).
// Parity beats are appended when S_P_DESER_PARITY_EN is defined.
module tb_s_p_deserializer;
    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       sin_valid = 1'b0, sin_sync = 1'b0, sin_data = 1'b0;
    logic       v2 = 1'b0, s2 = 1'b0;
    logic [1:0] d2 = 2'b00;
    logic       pout_ready = 1'b1;
    logic [7:0] dm_data, dl_data, d2_data;
    logic       dm_valid, dl_valid, d2_valid;
    logic       dm_ovr, dl_ovr, d2_ovr;
    logic       dm_ferr, dl_ferr, d2_ferr;
    int         total = 0;
    int         bad = 0;

    always #5 CK = ~CK;

    s_p_deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) dut_m (
        .CK(CK), .RST(RST), .SIN_VALID(sin_valid), .SIN_SYNC(sin_sync), .SIN_DATA(sin_data),
        .POUT_DATA(dm_data), .POUT_VALID(dm_valid), .POUT_READY(pout_ready),
        .OVERRUN(dm_ovr), .FRAME_ERR(dm_ferr)
    );
    s_p_deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) dut_l (
        .CK(CK), .RST(RST), .SIN_VALID(sin_valid), .SIN_SYNC(sin_sync), .SIN_DATA(sin_data),
        .POUT_DATA(dl_data), .POUT_VALID(dl_valid), .POUT_READY(pout_ready),
        .OVERRUN(dl_ovr), .FRAME_ERR(dl_ferr)
    );
    s_p_deserializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) dut_2 (
        .CK(CK), .RST(RST), .SIN_VALID(v2), .SIN_SYNC(s2), .SIN_DATA(d2),
        .POUT_DATA(d2_data), .POUT_VALID(d2_valid), .POUT_READY(pout_ready),
        .OVERRUN(d2_ovr), .FRAME_ERR(d2_ferr)
    );

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic step(input logic v, input logic s, input logic d);
        sin_valid = v; sin_sync = s; sin_data = d;
        @(posedge CK); #1;
    endtask

    task automatic step2(input logic v, input logic s, input logic [1:0] d);
        v2 = v; s2 = s; d2 = d;
        @(posedge CK); #1;
    endtask

    // rdy_last is applied only for the beat that completes the word.
    task automatic send_word(input logic [7:0] w, input logic sync0, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
`ifndef S_P_DESER_PARITY_EN
            if (i == 0) pout_ready = rdy_last;
`endif
            step(1'b1, sync0 && (i == 7), w[i]);
        end
`ifdef S_P_DESER_PARITY_EN
        pout_ready = rdy_last;
        step(1'b1, 1'b0, ^w);
`endif
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) @(posedge CK);
        #1;
        total++; if (dm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dm_valid); end
        total++; if (dm_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", dm_data); end
        total++; if ({dm_ovr, dm_ferr} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {dm_ovr, dm_ferr}); end
        RST = 1'b0;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bit_order;
        logic [7:0] w;
        w = 8'hB2;
        pout_ready = 1'b1;
        for (int i = 7; i >= 1; i--) step(1'b1, i == 7, w[i]);
        total++; if (dm_valid !== 1'b0) begin bad++; $display("FAIL order_early_valid got=%b exp=0", dm_valid); end
        step(1'b1, 1'b0, w[0]);
`ifdef S_P_DESER_PARITY_EN
        step(1'b1, 1'b0, ^w);
`endif
        total++; if (dm_valid !== 1'b1) begin bad++; $display("FAIL order_msb_valid got=%b exp=1", dm_valid); end
        total++; if (dm_data !== 8'hB2) begin bad++; $display("FAIL order_msb_data got=%h exp=b2", dm_data); end
        total++; if (dl_data !== 8'h4D) begin bad++; $display("FAIL order_lsb_data got=%h exp=4d", dl_data); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (dm_valid !== 1'b0) begin bad++; $display("FAIL order_one_cycle got=%b exp=0", dm_valid); end
    endtask

    task automatic test_lanes2;
        step2(1'b1, 1'b1, 2'd2);
        step2(1'b1, 1'b0, 2'd3);
        step2(1'b1, 1'b0, 2'd0);
        total++; if (d2_valid !== 1'b0) begin bad++; $display("FAIL lanes2_early got=%b exp=0", d2_valid); end
        step2(1'b1, 1'b0, 2'd2);
`ifdef S_P_DESER_PARITY_EN
        step2(1'b1, 1'b0, 2'd0);
`endif
        total++; if (d2_valid !== 1'b1) begin bad++; $display("FAIL lanes2_valid got=%b exp=1", d2_valid); end
        total++; if (d2_data !== 8'hB2) begin bad++; $display("FAIL lanes2_data got=%h exp=b2", d2_data); end
        step2(1'b0, 1'b0, 2'd0);
    endtask

    task automatic test_backpressure;
        pout_ready = 1'b0;
        send_word(8'hB2, 1'b1, 1'b0);
        total++; if (dm_valid !== 1'b1 || dm_data !== 8'hB2) begin bad++; $display("FAIL bp_first got=%b/%h exp=1/b2", dm_valid, dm_data); end
        send_word(8'h11, 1'b1, 1'b0);
        total++; if (dm_ovr !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b exp=1", dm_ovr); end
        total++; if (dm_data !== 8'hB2) begin bad++; $display("FAIL bp_held got=%h exp=b2", dm_data); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (dm_ovr !== 1'b0 || dm_valid !== 1'b1) begin bad++; $display("FAIL bp_pulse_end got=%b/%b exp=0/1", dm_ovr, dm_valid); end
        pout_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        total++; if (dm_valid !== 1'b0 || dm_data !== 8'hB2) begin bad++; $display("FAIL bp_drain got=%b/%h exp=0/b2", dm_valid, dm_data); end
    endtask

    task automatic test_back_to_back;
        pout_ready = 1'b0;
        send_word(8'hB2, 1'b1, 1'b0);
        send_word(8'h11, 1'b1, 1'b1);
        total++; if (dm_valid !== 1'b1 || dm_data !== 8'h11) begin bad++; $display("FAIL b2b_load got=%b/%h exp=1/11", dm_valid, dm_data); end
        total++; if (dm_ovr !== 1'b0) begin bad++; $display("FAIL b2b_no_overrun got=%b exp=0", dm_ovr); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (dm_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", dm_valid); end
    endtask

    task automatic test_frame_err;
        logic [7:0] w;
        w = 8'hB2;
        pout_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        total++; if (dm_ferr !== 1'b0) begin bad++; $display("FAIL ferr_sync_at_0 got=%b exp=0", dm_ferr); end
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, w[7]);
        total++; if (dm_ferr !== 1'b1 || dm_valid !== 1'b0) begin bad++; $display("FAIL ferr_mid got=%b/%b exp=1/0", dm_ferr, dm_valid); end
        step(1'b1, 1'b0, w[6]);
        total++; if (dm_ferr !== 1'b0) begin bad++; $display("FAIL ferr_one_cycle got=%b exp=0", dm_ferr); end
        for (int i = 5; i >= 0; i--) step(1'b1, 1'b0, w[i]);
`ifdef S_P_DESER_PARITY_EN
        step(1'b1, 1'b0, ^w);
`endif
        total++; if (dm_valid !== 1'b1 || dm_data !== 8'hB2) begin bad++; $display("FAIL ferr_recover got=%b/%h exp=1/b2", dm_valid, dm_data); end
        step(1'b0, 1'b0, 1'b0);
        // sync landing on the last beat is still a mid-word sync
        for (int i = 7; i >= 1; i--) step(1'b1, i == 7, w[i]);
        step(1'b1, 1'b1, w[7]);
        total++; if (dm_ferr !== 1'b1 || dm_valid !== 1'b0) begin bad++; $display("FAIL ferr_last_beat got=%b/%b exp=1/0", dm_ferr, dm_valid); end
        for (int i = 6; i >= 0; i--) step(1'b1, 1'b0, w[i]);
`ifdef S_P_DESER_PARITY_EN
        step(1'b1, 1'b0, ^w);
`endif
        total++; if (dm_valid !== 1'b1 || dm_data !== 8'hB2) begin bad++; $display("FAIL ferr_last_recover got=%b/%h exp=1/b2", dm_valid, dm_data); end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_idle_gaps;
        logic [7:0] w;
        logic       early;
        w = 8'hB2;
        early = 1'b0;
        pout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, i == 7, w[i]);
            if (i != 0) begin
                early = early | dm_valid | dm_ferr;
                step(1'b0, 1'b1, ~w[i]);
                early = early | dm_valid | dm_ferr;
            end
        end
`ifdef S_P_DESER_PARITY_EN
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, ^w);
`endif
        total++; if (early !== 1'b0) begin bad++; $display("FAIL gaps_early got=%b exp=0", early); end
        total++; if (dm_valid !== 1'b1 || dm_data !== 8'hB2) begin bad++; $display("FAIL gaps_word got=%b/%h exp=1/b2", dm_valid, dm_data); end
    endtask

    task automatic test_async_reset;
        logic spurious;
        pout_ready = 1'b0;
        step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1);
        total++; if (dm_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_hold got=%b exp=1", dm_valid); end
        sin_valid = 1'b1; sin_sync = 1'b0; sin_data = 1'b0;
        #2 RST = 1'b1;
        #1;
        total++; if (dm_valid !== 1'b0 || dm_data !== 8'h00 || dl_data !== 8'h00) begin
            bad++; $display("FAIL arst_immediate got=%b/%h/%h exp=0/00/00", dm_valid, dm_data, dl_data); end
        total++; if ({dm_ovr, dm_ferr} !== 2'b00) begin bad++; $display("FAIL arst_pulses got=%b exp=00", {dm_ovr, dm_ferr}); end
        RST = 1'b0;
        pout_ready = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, i[0]);
            spurious = spurious | dm_valid | dm_ferr | dm_ovr;
        end
        total++; if (spurious !== 1'b0) begin bad++; $display("FAIL arst_hunt got=%b exp=0", spurious); end
        send_word(8'h1D, 1'b1, 1'b1);
        total++; if (dm_valid !== 1'b1 || dm_data !== 8'h1D) begin bad++; $display("FAIL arst_resync got=%b/%h exp=1/1d", dm_valid, dm_data); end
        total++; if (dl_data !== 8'hB8) begin bad++; $display("FAIL arst_resync_lsb got=%h exp=b8", dl_data); end
        step(1'b0, 1'b0, 1'b0);
    endtask

`ifdef S_P_DESER_PARITY_EN
    task automatic test_parity;
        logic [7:0] w;
        w = 8'hB2;
        pout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) step(1'b1, i == 7, w[i]);
        total++; if (dm_valid !== 1'b0) begin bad++; $display("FAIL par_wait got=%b exp=0", dm_valid); end
        step(1'b1, 1'b0, 1'b1);
        total++; if (dm_ferr !== 1'b1 || dm_valid !== 1'b0) begin bad++; $display("FAIL par_bad got=%b/%b exp=1/0", dm_ferr, dm_valid); end
        for (int i = 7; i >= 0; i--) step(1'b1, i == 7, w[i]);
        step(1'b1, 1'b0, 1'b0);
        total++; if (dm_valid !== 1'b1 || dm_ferr !== 1'b0) begin bad++; $display("FAIL par_good got=%b/%b exp=1/0", dm_valid, dm_ferr); end
        step(1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_bit_order();
        test_lanes2();
        test_backpressure();
        test_back_to_back();
        test_frame_err();
        test_idle_gaps();
        test_async_reset();
`ifdef S_P_DESER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
